// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared types and constants for the UART command controller: FSM state
// encoding, frame byte values, command codes, parity encodings and small
// helpers describing the argument count of each command.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_CMD = 3'd1,
    ST_GET_ARG = 3'd2,
    ST_TX_ACK  = 3'd3,
    ST_TX_D0   = 3'd4,
    ST_TX_D1   = 3'd5,
    ST_TX_NAK  = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam logic [7:0] RESET_KEY = 8'h5A;

  localparam logic [7:0] CMD_SET_DIV  = 8'h01;
  localparam logic [7:0] CMD_SET_MODE = 8'h02;
  localparam logic [7:0] CMD_READ_CFG = 8'h03;
  localparam logic [7:0] CMD_RESET    = 8'h04;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2,
    PARITY_RSVD = 2'd3
  } parity_t;

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_SET_DIV) || (cmd == CMD_SET_MODE) ||
           (cmd == CMD_READ_CFG) || (cmd == CMD_RESET);
  endfunction

  function automatic logic [1:0] cmd_nargs(input logic [7:0] cmd);
    logic [1:0] n;
    n = 2'd0;
    case (cmd)
      CMD_SET_DIV:             n = 2'd2;
      CMD_SET_MODE, CMD_RESET: n = 2'd1;
      default:                 n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout
// Inter-byte timeout for frame reception. Down-counter reloaded to CYCLES-1
// by `clear`, decremented while `enable` is high, and flagging `expired` at
// terminal count while enabled. With a clear on the byte that enters a wait
// state, `expired` is seen on the CYCLES-th consecutive idle cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : reload the counter
//   enable     : count down (frame-wait states)
//   expired    : terminal count reached while enabled
module uart_cmd_timeout #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Decodes framed host commands (A5, CMD, 0..2 args) from the UART receive
// stream, programs the runtime configuration and answers with ACK/NAK (plus
// the divisor for READ_CFG) through the transmitter handshake.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   rx_data/valid/error     : received byte stream with error strobe
//   tx_data/valid, tx_ready : registered transmit handshake
//   cfg_divisor/parity/loopback : UART runtime configuration
//   reset_strobe            : one-cycle pulse after a RESET command's ACK leaves
//   busy                    : FSM not idle
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | waiting for SYNC byte, everything else ignored
// GET_CMD    | waiting for command byte
// GET_ARG    | collecting argument bytes, arg_cnt left to receive
// TX_ACK     | presenting ACK, waiting for transfer
// TX_D0      | READ_CFG: presenting divisor low byte
// TX_D1      | READ_CFG: presenting divisor high byte
// TX_NAK     | presenting NAK, waiting for transfer
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [15:0] DIV_RESET      = 16'd26,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] cfg_divisor,
  output logic [1:0]  cfg_parity,
  output logic        cfg_loopback,
  output logic        reset_strobe,
  output logic        busy
);

  state_t      state;
  logic [7:0]  cmd;
  logic [7:0]  arg_lo;
  logic [1:0]  arg_cnt;
  logic [15:0] div_snap;

  logic in_wait;
  logic to_clear;
  logic to_expired;
  logic xfer;

  assign in_wait  = (state == ST_GET_CMD) || (state == ST_GET_ARG);
  assign to_clear = rx_valid || !in_wait;
  assign xfer     = tx_valid && tx_ready;

  uart_cmd_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (in_wait),
    .expired (to_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      cfg_divisor  <= DIV_RESET;
      cfg_parity   <= PARITY_NONE;
      cfg_loopback <= 1'b0;
      reset_strobe <= 1'b0;
      cmd          <= 8'h00;
      arg_lo       <= 8'h00;
      arg_cnt      <= 2'd0;
      div_snap     <= 16'h0000;
    end else begin
      reset_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid && !rx_error && (rx_data == SYNC_BYTE)) begin
            state <= ST_GET_CMD;
            busy  <= 1'b1;
          end
        end

        ST_GET_CMD: begin
          // error wins over a simultaneous valid byte
          if (rx_error) begin
            state    <= ST_TX_NAK;
            tx_valid <= 1'b1;
            tx_data  <= NAK_BYTE;
          end else if (rx_valid) begin
            cmd <= rx_data;
            if (!cmd_known(rx_data)) begin
              state    <= ST_TX_NAK;
              tx_valid <= 1'b1;
              tx_data  <= NAK_BYTE;
            end else if (cmd_nargs(rx_data) == 2'd0) begin
              state    <= ST_TX_ACK;
              tx_valid <= 1'b1;
              tx_data  <= ACK_BYTE;
              div_snap <= cfg_divisor;
            end else begin
              state   <= ST_GET_ARG;
              arg_cnt <= cmd_nargs(rx_data);
            end
          end else if (to_expired) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        ST_GET_ARG: begin
          if (rx_error) begin
            state    <= ST_TX_NAK;
            tx_valid <= 1'b1;
            tx_data  <= NAK_BYTE;
          end else if (rx_valid) begin
            if (arg_cnt == 2'd1) begin
              // final argument: execute and answer in the same edge
              state    <= ST_TX_ACK;
              tx_valid <= 1'b1;
              tx_data  <= ACK_BYTE;
              div_snap <= cfg_divisor;
              case (cmd)
                CMD_SET_DIV: cfg_divisor <= {rx_data, arg_lo};
                CMD_SET_MODE: begin
                  cfg_parity   <= rx_data[1:0];
                  cfg_loopback <= rx_data[2];
                end
                CMD_RESET: begin
                  if (rx_data != RESET_KEY) begin
                    state   <= ST_TX_NAK;
                    tx_data <= NAK_BYTE;
                  end
                end
                default: begin
                  state   <= ST_TX_NAK;
                  tx_data <= NAK_BYTE;
                end
              endcase
            end else begin
              arg_lo  <= rx_data;
              arg_cnt <= arg_cnt - 2'd1;
            end
          end else if (to_expired) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        ST_TX_ACK: begin
          if (xfer) begin
            if (cmd == CMD_READ_CFG) begin
              state   <= ST_TX_D0;
              tx_data <= div_snap[7:0];
            end else begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              tx_valid <= 1'b0;
              // only a keyed RESET reaches TX_ACK with this command
              if (cmd == CMD_RESET) reset_strobe <= 1'b1;
            end
          end
        end

        ST_TX_D0: begin
          if (xfer) begin
            state   <= ST_TX_D1;
            tx_data <= div_snap[15:8];
          end
        end

        ST_TX_D1, ST_TX_NAK: begin
          if (xfer) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl
// Self-checking bench: hand sequences, a table of frames with expected
// responses/config, and random frames checked against a frame-level model.
module tb_uart_cmd_ctrl;

  localparam int TO = 100;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [15:0] DIV_DEF = 16'd26;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_error = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] cfg_divisor;
  logic [1:0]  cfg_parity;
  logic        cfg_loopback;
  logic        reset_strobe;
  logic        busy;

  uart_cmd_ctrl #(
    .DIV_RESET      (DIV_DEF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_error     (rx_error),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .cfg_divisor  (cfg_divisor),
    .cfg_parity   (cfg_parity),
    .cfg_loopback (cfg_loopback),
    .reset_strobe (reset_strobe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level model state
  logic [15:0] m_div = DIV_DEF;
  logic [1:0]  m_par = 2'd0;
  logic        m_lb = 1'b0;
  int          m_str = 0;

  logic [7:0] fr_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         fr_err;

  // transmit monitor
  bit   rdy_en = 1'b0;
  bit   mon_en = 1'b0;
  int   strobe_cnt = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_xfer_ack = 1'b0, prev_strobe = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      tx_ready = rdy_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en && prev_valid && !prev_ready) begin
      chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
      chk("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_data});
    end
    if (reset_strobe) begin
      strobe_cnt++;
      chk("strobe_after_ack", {31'd0, prev_xfer_ack}, 32'd1);
      chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
    end
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    prev_xfer_ack = tx_valid && tx_ready && (tx_data == ACK);
    prev_valid    = tx_valid;
    prev_ready    = tx_ready;
    prev_data     = tx_data;
    prev_strobe   = reset_strobe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_error = err;
    tick();
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic check_cfg(input string tag, input logic [15:0] d, input logic [1:0] p, input logic l);
    chk({tag, "_div"}, {16'd0, cfg_divisor}, {16'd0, d});
    chk({tag, "_par"}, {30'd0, cfg_parity}, {30'd0, p});
    chk({tag, "_lb"}, {31'd0, cfg_loopback}, {31'd0, l});
  endtask

  // Sends fr_q (error strobe on byte fr_err), checks 1-cycle config/response
  // latency, then collects and compares the response bytes against exp_q.
  task automatic run_frame(input logic [15:0] nd, input logic [1:0] np, input logic nl,
                           input int nstr, input bit stray);
    int k;
    rdy_en = 1'b0;
    for (int i = 0; i < fr_q.size(); i++) begin
      if (i == fr_q.size() - 1) check_cfg("cfg_before_last", m_div, m_par, m_lb);
      send_byte(fr_q[i], (i == fr_err));
      if (i != fr_q.size() - 1) repeat ($urandom_range(0, 2)) tick();
    end
    check_cfg("cfg_after_last", nd, np, nl);
    if (exp_q.size() > 0) begin
      chk("resp_latency_valid", {31'd0, tx_valid}, 32'd1);
      chk("resp_latency_data", {24'd0, tx_data}, {24'd0, exp_q[0]});
    end else begin
      chk("no_resp_valid", {31'd0, tx_valid}, 32'd0);
      chk("no_resp_busy", {31'd0, busy}, 32'd0);
    end
    if (stray) begin
      tick();
      send_byte(8'hA5, 1'b0);
    end
    rdy_en = 1'b1;
    k = 0;
    while (!((got_q.size() >= exp_q.size()) && !busy && !tx_valid) && (k < 400)) begin
      tick();
      k++;
    end
    if (k >= 400) chk("resp_wait_timeout", 32'd1, 32'd0);
    repeat (3) tick();
    chk("resp_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("resp_byte", {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    chk("strobe_count", strobe_cnt, nstr);
    chk("idle_after_frame", {31'd0, busy}, 32'd0);
    got_q.delete();
    m_div = nd;
    m_par = np;
    m_lb  = nl;
    m_str = nstr;
  endtask

  typedef struct {
    int          n;
    logic [31:0] b;
    int          err;
    int          nr;
    logic [23:0] r;
    logic [15:0] div;
    logic [1:0]  par;
    logic        lb;
    int          str;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [31:0] b, input int err, input int nr,
                              input logic [23:0] r, input logic [15:0] div,
                              input logic [1:0] par, input logic lb, input int str);
    vec_t v;
    v.n = n; v.b = b; v.err = err; v.nr = nr; v.r = r;
    v.div = div; v.par = par; v.lb = lb; v.str = str;
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    fr_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.n; i++) fr_q.push_back(v.b[8*i +: 8]);
    for (int i = 0; i < v.nr; i++) exp_q.push_back(v.r[8*i +: 8]);
    fr_err = v.err;
  endtask

  logic [15:0] g_div;
  logic [1:0]  g_par;
  logic        g_lb;
  int          g_str;

  // Random frame plus expected result, from the command rules directly.
  task automatic gen_frame();
    int kind, na;
    logic [7:0] c, a0, a1;
    fr_q.delete();
    exp_q.delete();
    fr_err = -1;
    g_div = m_div; g_par = m_par; g_lb = m_lb; g_str = m_str;
    fr_q.push_back(8'hA5);
    kind = int'($urandom_range(0, 5));
    a0 = 8'($urandom);
    a1 = 8'($urandom);
    if (kind == 5) begin
      fr_q.push_back(8'($urandom));
      fr_err = 1;
      exp_q.push_back(NAK);
    end else if (kind == 4) begin
      fr_q.push_back(8'($urandom_range(5, 255)));
      exp_q.push_back(NAK);
    end else begin
      c = 8'(kind + 1);
      if ((c == 8'h04) && ($urandom_range(0, 1) == 1)) a0 = 8'h5A;
      na = (c == 8'h01) ? 2 : (c == 8'h03) ? 0 : 1;
      fr_q.push_back(c);
      if (na >= 1) fr_q.push_back(a0);
      if (na == 2) fr_q.push_back(a1);
      if ((na > 0) && ($urandom_range(0, 4) == 0)) begin
        fr_err = 2 + int'($urandom_range(0, na - 1));
        while (fr_q.size() > fr_err + 1) void'(fr_q.pop_back());
      end
      if (fr_err >= 0) exp_q.push_back(NAK);
      else begin
        case (c)
          8'h01: begin g_div = {a1, a0}; exp_q.push_back(ACK); end
          8'h02: begin g_par = a0[1:0]; g_lb = a0[2]; exp_q.push_back(ACK); end
          8'h03: begin exp_q.push_back(ACK); exp_q.push_back(g_div[7:0]); exp_q.push_back(g_div[15:8]); end
          default: begin
            if (a0 == 8'h5A) begin exp_q.push_back(ACK); g_str = g_str + 1; end
            else exp_q.push_back(NAK);
          end
        endcase
      end
    end
  endtask

  vec_t vt[14];

  initial begin
    vt[0]  = mk(4, 32'h123401A5, -1, 1, 24'h000006, 16'h1234, 2'd0, 1'b0, 0);
    vt[1]  = mk(2, 32'h000003A5, -1, 3, 24'h123406, 16'h1234, 2'd0, 1'b0, 0);
    vt[2]  = mk(3, 32'h000502A5, -1, 1, 24'h000006, 16'h1234, 2'd1, 1'b1, 0);
    vt[3]  = mk(2, 32'h000007A5, -1, 1, 24'h000015, 16'h1234, 2'd1, 1'b1, 0);
    vt[4]  = mk(3, 32'h000302A5,  2, 1, 24'h000015, 16'h1234, 2'd1, 1'b1, 0);
    vt[5]  = mk(3, 32'h000004A5, -1, 1, 24'h000015, 16'h1234, 2'd1, 1'b1, 0);
    vt[6]  = mk(3, 32'h005A04A5, -1, 1, 24'h000006, 16'h1234, 2'd1, 1'b1, 1);
    vt[7]  = mk(4, 32'h000001A5, -1, 1, 24'h000006, 16'h0000, 2'd1, 1'b1, 1);
    vt[8]  = mk(2, 32'h000003A5, -1, 3, 24'h000006, 16'h0000, 2'd1, 1'b1, 1);
    vt[9]  = mk(2, 32'h0000A5A5, -1, 1, 24'h000015, 16'h0000, 2'd1, 1'b1, 1);
    vt[10] = mk(2, 32'h000001A5,  1, 1, 24'h000015, 16'h0000, 2'd1, 1'b1, 1);
    vt[11] = mk(2, 32'h0000FF00, -1, 0, 24'h000000, 16'h0000, 2'd1, 1'b1, 1);
    vt[12] = mk(3, 32'h00FA02A5, -1, 1, 24'h000006, 16'h0000, 2'd2, 1'b0, 1);
    vt[13] = mk(4, 32'h12A501A5, -1, 1, 24'h000006, 16'h12A5, 2'd2, 1'b0, 1);

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_strobe", {31'd0, reset_strobe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    check_cfg("rst", DIV_DEF, 2'd0, 1'b0);
    tick();
    mon_en = 1'b1;

    // READ_CFG straight after reset
    fr_q = {8'hA5, 8'h03};
    exp_q = {ACK, 8'h1A, 8'h00};
    fr_err = -1;
    run_frame(DIV_DEF, 2'd0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      load_vec(vt[i]);
      run_frame(vt[i].div, vt[i].par, vt[i].lb, vt[i].str, 1'b0);
      repeat (2) tick();
    end

    // byte arriving while the response is stalled must be dropped
    fr_q = {8'hA5, 8'h03};
    exp_q = {ACK, 8'hA5, 8'h12};
    fr_err = -1;
    run_frame(m_div, m_par, m_lb, m_str, 1'b1);
    repeat (5) tick();
    chk("stray_dropped_busy", {31'd0, busy}, 32'd0);

    // timeout abandons a partial frame silently
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h34, 1'b0);
    repeat (TO - 1) tick();
    chk("timeout_busy_before", {31'd0, busy}, 32'd1);
    repeat (2) tick();
    chk("timeout_busy_after", {31'd0, busy}, 32'd0);
    chk("timeout_no_tx", {31'd0, tx_valid}, 32'd0);
    chk("timeout_no_resp", got_q.size(), 0);
    fr_q = {8'hA5, 8'h02, 8'h05};
    exp_q = {ACK};
    fr_err = -1;
    run_frame(m_div, 2'd1, 1'b1, m_str, 1'b0);

    for (int n = 0; n < 40; n++) begin
      gen_frame();
      run_frame(g_div, g_par, g_lb, g_str, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end

    // reset while a response is stalled
    rdy_en = 1'b0;
    tick();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    tick();
    chk("pre_reset_tx_valid", {31'd0, tx_valid}, 32'd1);
    mon_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    check_cfg("mid_reset", DIV_DEF, 2'd0, 1'b0);
    chk("mid_reset_no_resp", got_q.size(), 0);
    tick();
    mon_en = 1'b1;
    m_div = DIV_DEF;
    m_par = 2'd0;
    m_lb  = 1'b0;
    fr_q = {8'hA5, 8'h03};
    exp_q = {ACK, 8'h1A, 8'h00};
    fr_err = -1;
    run_frame(DIV_DEF, 2'd0, 1'b0, m_str, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command/configuration controller for the SpinalHDL UART. It consumes the received byte stream and decodes framed host commands. It programs the UART's runtime configuration (baud divisor, parity, loopback) and answers each frame with ACK/NAK bytes through the transmitter. It also raises the one-cycle command-reset strobe that feeds the design's reset controller.

## Interface
- `DIV_RESET`, 16'd26: `cfg_divisor` value after reset.
- `TIMEOUT_CYCLES`, 1024: idle cycles inside a frame before the frame is abandoned (≥2).
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `rx_error` in 1: one-cycle strobe, framing/parity error on the current byte.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: transmitter accepts the byte this cycle.
- `cfg_divisor` out 16: baud divisor.
- `cfg_parity` out 2: 0 none, 1 even, 2 odd, 3 reserved (treated as none by the UART).
- `cfg_loopback` out 1: internal loopback enable.
- `reset_strobe` out 1: one-cycle command reset pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
Frame format: SYNC 0xA5, then CMD, then 0–2 ARG bytes.

Commands:
- 0x01 SET_DIV, 2 args: lo, then hi.
- 0x02 SET_MODE, 1 arg:
  - bits[1:0] → `cfg_parity`.
  - bit2 → `cfg_loopback`.
  - bits[7:3] ignored.
- 0x03 READ_CFG, 0 args. Response is ACK, divisor lo, divisor hi.
- 0x04 RESET, 1 arg, which must equal 0x5A.

Responses:
- ACK is 0x06.
- NAK is 0x15.

States:
- IDLE
  - `rx_valid` with 0xA5 → GET_CMD.
  - Any other byte is ignored.
  - `rx_error` is ignored.
- GET_CMD
  - Known command with args → GET_ARG, with the arg counter loaded to 2 or 1.
  - 0x03 → TX_ACK.
  - Unknown command → TX_NAK.
- GET_ARG
  - Each byte is stored and the counter decrements.
  - On the last arg the command executes, then → TX_ACK.
  - RESET with an arg other than 0x5A → TX_NAK, with no strobe.
- TX_ACK → TX_D0 → TX_D1 → IDLE for READ_CFG. For every other command, TX_ACK → IDLE.
- TX_NAK → IDLE.
- A TX state advances only on a `tx_valid && tx_ready` transfer.

Execution effects:
- SET_DIV: `cfg_divisor` = {hi, lo}, updated in the cycle after the hi byte strobe.
- SET_MODE: `cfg_parity` and `cfg_loopback` updated in the cycle after the arg strobe.
- RESET: `reset_strobe` pulses high for exactly one cycle, in the cycle after the ACK transfer. This guarantees the ACK leaves before the design resets.
- A divisor of 0 is accepted as written; the UART treats 0 as 1.

Boundary conditions:
- `rx_error` in GET_CMD or GET_ARG → TX_NAK. No configuration changes.
- `rx_valid` while in any TX state → byte dropped. Bytes are not queued.
- 0xA5 received in GET_CMD or GET_ARG is treated as data, not as a resync.
- Timeout: a counter clears on every `rx_valid`. After `TIMEOUT_CYCLES` cycles in GET_CMD/GET_ARG without `rx_valid` → IDLE silently, with no response.
- `rx_valid` and `rx_error` in the same cycle: the error takes priority.
- `reset` mid-frame or mid-transmit:
  - Immediately returns to IDLE.
  - Drops `tx_valid`.
  - Restores the configuration defaults.

## Timing
Reset values:
- `tx_valid` 0, `tx_data` 0x00.
- `cfg_divisor` `DIV_RESET`, `cfg_parity` 0, `cfg_loopback` 0.
- `reset_strobe` 0, `busy` 0.

Latencies:
- Final `rx_valid` of a frame → `tx_valid` high with ACK/NAK: 1 cycle.
- Config register update: 1 cycle after the final byte strobe.

TX handshake:
- `tx_valid` and `tx_data` are registered.
- Once `tx_valid` is high, `tx_data` stays stable until the transfer.
- After a transfer, the next byte (TX_D0/TX_D1) is presented the following cycle.
- `tx_valid` may be low for one cycle between bytes.
- READ_CFG returns the divisor value sampled at TX_ACK entry.

All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `uart_cmd_pkg`:
  - State enum.
  - Constants SYNC=0xA5, ACK=0x06, NAK=0x15, RESET_KEY=0x5A.
  - Command codes 0x01–0x04.
  - Parity encodings.
- Sub-module `uart_cmd_timeout`: loadable down-counter with a `clear` input and an `expired` output.
- FSM and config registers live in `uart_cmd_ctrl`.

## Test plan
- SET_DIV: A5 01 34 12 → ACK 0x06 transmitted; `cfg_divisor` = 0x1234 one cycle after the 0x12 strobe.
- READ_CFG after reset: A5 03 → bytes 0x06, 0x1A, 0x00 in order with `tx_ready` toggling randomly; `tx_data` stable while stalled.
- RESET: A5 04 5A → ACK, then `reset_strobe` high exactly 1 cycle after the ACK transfer. A5 04 00 → NAK 0x15, no strobe.
- Errors: A5 07 → NAK. A5 02 with `rx_error` on the arg → NAK, `cfg_parity`/`cfg_loopback` unchanged. Garbage 0x00 0xFF in IDLE → no response.
- Timeout: A5 01 34, then silence for `TIMEOUT_CYCLES` → `busy` falls. A following A5 02 05 → ACK; parity=1, loopback=1.
- `reset` asserted while `tx_valid` is high with `tx_ready` low → next cycle `tx_valid` 0, `busy` 0, config back to defaults.
